// File: rtl/decode_pipe.sv
// Instruction decode stage with hazard detection, a multiply scoreboard and the ID/EX register.
// Define DECODE_FORWARD_EN to forward EX/MEM results; when it is undefined every EX/MEM RAW hazard stalls.
module decode_pipe #(
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       instruction,
    output logic [4:0]        src_reg1,
    output logic [4:0]        src_reg2,
    input  logic [REG_W-1:0]  rin_reg1,
    input  logic [REG_W-1:0]  rin_reg2,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [4:0]        ex_dest_reg,
    input  logic              m_regwrite,
    input  logic [4:0]        m_dest_reg,
    input  logic [REG_W-1:0]  ex_result,
    input  logic [REG_W-1:0]  m_result,
    input  logic              flush,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [6:0]        out_opcode,
    output logic [REG_W-1:0]  rout_reg1,
    output logic [REG_W-1:0]  rout_reg2,
    output logic [4:0]        dest_reg,
    output logic [ADDR_W-1:0] mimmediat,
    output logic              is_mult,
    output logic              mul_busy
);

    localparam logic [6:0] OPCODE_MUL  = 7'h12;
    localparam logic [6:0] OPCODE_BEQ  = 7'h13;
    localparam logic [6:0] OPCODE_JUMP = 7'h14;
    localparam logic [3:0] MUL_LAT_C   = 4'(MUL_LAT);

    logic [6:0]        opcode;
    logic [4:0]        dst;
    logic [3:0]        mul_cnt;
    logic [3:0]        mul_cnt_next;
    logic [4:0]        mul_dest;
    logic              ex_m1, ex_m2, mem_m1, mem_m2;
    logic              load_use, mul_raw, mul_struct, hazard;
    logic              stall, issue, issue_mul;
    logic [REG_W-1:0]  op1, op2;
    logic [ADDR_W-1:0] imm;

    function automatic logic match(input logic [4:0] src, input logic wr, input logic [4:0] dest);
        return wr && (dest == src) && (src != 5'd0);
    endfunction

    assign opcode   = instruction[31:25];
    assign dst      = instruction[24:20];
    assign src_reg1 = instruction[19:15];
    assign src_reg2 = instruction[14:10];

    assign ex_m1  = match(src_reg1, ex_regwrite, ex_dest_reg);
    assign ex_m2  = match(src_reg2, ex_regwrite, ex_dest_reg);
    assign mem_m1 = match(src_reg1, m_regwrite, m_dest_reg);
    assign mem_m2 = match(src_reg2, m_regwrite, m_dest_reg);

    assign load_use   = ex_memread && (ex_m1 || ex_m2);
    assign mul_raw    = mul_busy && (((src_reg1 != 5'd0) && (src_reg1 == mul_dest)) ||
                                     ((src_reg2 != 5'd0) && (src_reg2 == mul_dest)));
    assign mul_struct = mul_busy && (opcode == OPCODE_MUL);

`ifdef DECODE_FORWARD_EN
    assign hazard = load_use || mul_raw || mul_struct;
    // EX is the younger producer, so it wins over MEM.
    assign op1 = ex_m1 ? ex_result : (mem_m1 ? m_result : rin_reg1);
    assign op2 = ex_m2 ? ex_result : (mem_m2 ? m_result : rin_reg2);
`else
    assign hazard = load_use || mul_raw || mul_struct || ex_m1 || ex_m2 || mem_m1 || mem_m2;
    assign op1 = rin_reg1;
    assign op2 = rin_reg2;
`endif

    assign stall       = in_valid && !flush && hazard;
    assign issue       = in_valid && !stall && !flush;
    assign issue_mul   = issue && (opcode == OPCODE_MUL);
    assign pc_write    = !stall;
    assign if_id_write = !stall;

    always_comb begin
        imm = {{(ADDR_W-15){instruction[14]}}, instruction[14:0]};
        case (opcode)
            OPCODE_BEQ:  imm = {{(ADDR_W-15){instruction[24]}}, instruction[24:20], instruction[9:0]};
            OPCODE_JUMP: imm = {{(ADDR_W-20){instruction[24]}}, instruction[24:20], instruction[14:0]};
            default:     imm = {{(ADDR_W-15){instruction[14]}}, instruction[14:0]};
        endcase
    end

    // Saturating down-counter: a new MUL reloads it, otherwise it drains to zero.
    always_comb begin
        mul_cnt_next = mul_cnt;
        if (issue_mul)
            mul_cnt_next = MUL_LAT_C;
        else if (mul_cnt != 4'd0)
            mul_cnt_next = mul_cnt - 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_cnt    <= '0;
            mul_busy   <= 1'b0;
            mul_dest   <= '0;
            out_valid  <= 1'b0;
            is_mult    <= 1'b0;
            out_pc     <= '0;
            out_opcode <= '0;
            rout_reg1  <= '0;
            rout_reg2  <= '0;
            dest_reg   <= '0;
            mimmediat  <= '0;
        end else begin
            mul_cnt  <= mul_cnt_next;
            mul_busy <= (mul_cnt_next != 4'd0);
            if (issue_mul)
                mul_dest <= dst;
            if (issue) begin
                out_valid  <= 1'b1;
                is_mult    <= (opcode == OPCODE_MUL);
                out_pc     <= pc;
                out_opcode <= opcode;
                rout_reg1  <= op1;
                rout_reg2  <= op2;
                dest_reg   <= dst;
                mimmediat  <= imm;
            end else begin
                // Stall or flush: inject a bubble, leave the data fields as they were.
                out_valid <= 1'b0;
                is_mult   <= 1'b0;
                dest_reg  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: decode fields, immediates, hazards, multiply scoreboard, flush and reset.
module tb_decode_pipe;

    localparam logic [6:0] OP_ADD  = 7'h10;
    localparam logic [6:0] OP_MUL  = 7'h12;
    localparam logic [6:0] OP_BEQ  = 7'h13;
    localparam logic [6:0] OP_JUMP = 7'h14;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [4:0]  src_reg1, src_reg2;
    logic [31:0] rin_reg1, rin_reg2;
    logic        ex_regwrite, ex_memread;
    logic [4:0]  ex_dest_reg;
    logic        m_regwrite;
    logic [4:0]  m_dest_reg;
    logic [31:0] ex_result, m_result;
    logic        flush;
    logic        pc_write, if_id_write;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [31:0] rout_reg1, rout_reg2;
    logic [4:0]  dest_reg;
    logic [31:0] mimmediat;
    logic        is_mult, mul_busy;

    int passed = 0;
    int total  = 0;

    decode_pipe #(.ADDR_W(32), .REG_W(32), .MUL_LAT(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .pc(pc), .instruction(instruction),
        .src_reg1(src_reg1), .src_reg2(src_reg2), .rin_reg1(rin_reg1), .rin_reg2(rin_reg2),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_dest_reg(ex_dest_reg),
        .m_regwrite(m_regwrite), .m_dest_reg(m_dest_reg), .ex_result(ex_result), .m_result(m_result),
        .flush(flush), .pc_write(pc_write), .if_id_write(if_id_write), .out_valid(out_valid),
        .out_pc(out_pc), .out_opcode(out_opcode), .rout_reg1(rout_reg1), .rout_reg2(rout_reg2),
        .dest_reg(dest_reg), .mimmediat(mimmediat), .is_mult(is_mult), .mul_busy(mul_busy)
    );

    always #5 clk = ~clk;

    // Register file model: register n reads as 0xA000_0000 + n.
    assign rin_reg1 = 32'hA000_0000 | {27'd0, src_reg1};
    assign rin_reg2 = 32'hA000_0000 | {27'd0, src_reg2};

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [9:0] lo);
        return {op, d, s1, s2, lo};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_hazards();
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_dest_reg = '0; ex_result = '0;
        m_regwrite  = 1'b0; m_dest_reg = '0;  m_result  = '0;  flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state before any clock edge
        reset = 1'b1; in_valid = 1'b0; pc = '0; instruction = '0;
        clear_hazards();
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_mul_busy", mul_busy, 0);
        check("rst_is_mult", is_mult, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_dest", dest_reg, 0);
        @(negedge clk); reset = 1'b0;

        // Plain ADD r3 <- r1, r2
        in_valid = 1'b1; pc = 32'h100; instruction = mk(OP_ADD, 5'd3, 5'd1, 5'd2, 10'h3FF);
        #1;
        check("src1_field", src_reg1, 1);
        check("src2_field", src_reg2, 2);
        check("add_pc_write", pc_write, 1);
        check("add_if_id_write", if_id_write, 1);
        @(negedge clk);
        check("add_valid", out_valid, 1);
        check("add_pc", out_pc, 32'h100);
        check("add_opcode", out_opcode, OP_ADD);
        check("add_dest", dest_reg, 3);
        check("add_rout1", rout_reg1, 32'hA000_0001);
        check("add_rout2", rout_reg2, 32'hA000_0002);
        check("add_imm", mimmediat, 32'h0000_0BFF);
        check("add_is_mult", is_mult, 0);

        // Immediate formats
        pc = 32'h104; instruction = mk(OP_BEQ, 5'h10, 5'd0, 5'd0, 10'h005);
        @(negedge clk);
        check("beq_imm", mimmediat, 32'hFFFF_C005);
        check("beq_pc", out_pc, 32'h104);
        pc = 32'h108; instruction = mk(OP_JUMP, 5'h1F, 5'd0, 5'd0, 10'h010);
        @(negedge clk);
        check("jump_imm_neg", mimmediat, 32'hFFFF_8010);
        instruction = mk(OP_JUMP, 5'h0F, 5'd0, 5'd1, 10'h000);
        @(negedge clk);
        check("jump_imm_pos", mimmediat, 32'h0007_8400);

        // EX RAW on src1
        pc = 32'h10C; instruction = mk(OP_ADD, 5'd3, 5'd1, 5'd2, 10'h0);
        ex_regwrite = 1'b1; ex_dest_reg = 5'd1; ex_result = 32'h55;
        #1;
`ifdef DECODE_FORWARD_EN
        check("exraw_pc_write", pc_write, 1);
        @(negedge clk);
        check("exraw_valid", out_valid, 1);
        check("exraw_fwd", rout_reg1, 32'h55);
`else
        check("exraw_pc_write", pc_write, 0);
        @(negedge clk);
        check("exraw_bubble", out_valid, 0);
        check("exraw_bubble_dest", dest_reg, 0);
`endif
        clear_hazards();
        #1;
        check("exraw_release", pc_write, 1);
        @(negedge clk);
        check("exraw_issue", out_valid, 1);
        check("exraw_issue_rout1", rout_reg1, 32'hA000_0001);
        check("exraw_issue_dest", dest_reg, 3);

        // MEM RAW on src2
        pc = 32'h110; instruction = mk(OP_ADD, 5'd6, 5'd0, 5'd2, 10'h0);
        m_regwrite = 1'b1; m_dest_reg = 5'd2; m_result = 32'h77;
        #1;
`ifdef DECODE_FORWARD_EN
        check("memraw_pc_write", pc_write, 1);
        @(negedge clk);
        check("memraw_fwd", rout_reg2, 32'h77);
`else
        check("memraw_pc_write", pc_write, 0);
        @(negedge clk);
        check("memraw_bubble", out_valid, 0);
`endif
        clear_hazards();

        // Load-use: one bubble then issue
        pc = 32'h114; instruction = mk(OP_ADD, 5'd6, 5'd4, 5'd0, 10'h0);
        ex_regwrite = 1'b1; ex_memread = 1'b1; ex_dest_reg = 5'd4;
        #1;
        check("lu_pc_write", pc_write, 0);
        check("lu_if_id_write", if_id_write, 0);
        @(negedge clk);
        check("lu_bubble", out_valid, 0);
        clear_hazards();
        #1;
        check("lu_release", pc_write, 1);
        @(negedge clk);
        check("lu_issue", out_valid, 1);
        check("lu_rout1", rout_reg1, 32'hA000_0004);
        check("lu_pc", out_pc, 32'h114);

        // Register 0 never hazards
        pc = 32'h118; instruction = mk(OP_ADD, 5'd7, 5'd0, 5'd0, 10'h0);
        ex_regwrite = 1'b1; ex_memread = 1'b1; ex_dest_reg = 5'd0; m_regwrite = 1'b1; m_dest_reg = 5'd0;
        #1;
        check("r0_pc_write", pc_write, 1);
        @(negedge clk);
        check("r0_issue", out_valid, 1);
        check("r0_dest", dest_reg, 7);
        clear_hazards();

        // MUL r5 then a dependent ADD: four stall cycles
        pc = 32'h11C; instruction = mk(OP_MUL, 5'd5, 5'd1, 5'd2, 10'h0);
        @(negedge clk);
        check("mul_is_mult", is_mult, 1);
        check("mul_busy_set", mul_busy, 1);
        pc = 32'h120; instruction = mk(OP_ADD, 5'd8, 5'd5, 5'd1, 10'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("mulraw_stall%0d", i), pc_write, 0);
            @(negedge clk);
            check($sformatf("mulraw_bubble%0d", i), out_valid, 0);
        end
        #1;
        check("mulraw_release", pc_write, 1);
        check("mulraw_busy_clear", mul_busy, 0);
        @(negedge clk);
        check("mulraw_issue", out_valid, 1);
        check("mulraw_dest", dest_reg, 8);

        // Back-to-back MULs: structural stall until the counter drains
        pc = 32'h124; instruction = mk(OP_MUL, 5'd9, 5'd1, 5'd2, 10'h0);
        @(negedge clk);
        check("mul9_is_mult", is_mult, 1);
        pc = 32'h128; instruction = mk(OP_MUL, 5'd10, 5'd1, 5'd2, 10'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("mulstr_stall%0d", i), pc_write, 0);
            @(negedge clk);
            check($sformatf("mulstr_is_mult%0d", i), is_mult, 0);
        end
        #1;
        check("mulstr_release", pc_write, 1);
        @(negedge clk);
        check("mul10_is_mult", is_mult, 1);
        check("mul10_busy", mul_busy, 1);
        check("mul10_dest", dest_reg, 10);

        // Flush wins over a load-use stall
        pc = 32'h12C; instruction = mk(OP_ADD, 5'd11, 5'd4, 5'd0, 10'h0);
        ex_regwrite = 1'b1; ex_memread = 1'b1; ex_dest_reg = 5'd4; flush = 1'b1;
        #1;
        check("flush_pc_write", pc_write, 1);
        @(negedge clk);
        check("flush_valid", out_valid, 0);
        check("flush_is_mult", is_mult, 0);
        check("flush_busy_kept", mul_busy, 1);
        clear_hazards();

        // Independent ADD while the MUL is still busy
        pc = 32'h130; instruction = mk(OP_ADD, 5'd12, 5'd1, 5'd2, 10'h0);
        @(negedge clk);
        check("busy_add_valid", out_valid, 1);
        check("busy_add_busy", mul_busy, 1);

        // Asynchronous reset between clock edges
        #2; reset = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", mul_busy, 0);
        check("arst_pc", out_pc, 0);
        check("arst_opcode", out_opcode, 0);
        check("arst_dest", dest_reg, 0);
        check("arst_rout1", rout_reg1, 0);
        check("arst_rout2", rout_reg2, 0);
        check("arst_imm", mimmediat, 0);
        @(negedge clk); reset = 1'b0;

        // Abandoned mul_dest (r10) must not stall
        pc = 32'h134; instruction = mk(OP_ADD, 5'd13, 5'd10, 5'd0, 10'h0);
        #1;
        check("post_rst_pc_write", pc_write, 1);
        check("post_rst_busy", mul_busy, 0);
        @(negedge clk);
        check("post_rst_issue", out_valid, 1);
        check("post_rst_dest", dest_reg, 13);

        in_valid = 1'b0;
        @(negedge clk);
        check("idle_valid", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
